// File: rtl/ntt_pkg.sv
// Shared constants and the bank map for the 512-point NTT address generator.
// The bank map skews words across 4 banks so that butterfly lanes never collide.
package ntt_pkg;

    localparam int LAT_R2 = 8;
    localparam int LAT_R4 = 14;
    localparam int AW     = 7;
    localparam int NBANK  = 4;
    localparam int DW     = 1 + NBANK * AW + 8;

    localparam logic [7:0] TW_BASE_R4 [4] = '{8'd0, 8'd1, 8'd5, 8'd21};
    localparam logic [7:0] TW_BASE_R2     = 8'd85;
    localparam logic [8:0] TW_INTT_OFS    = 9'd256;

    function automatic logic [1:0] bank_of(input logic [8:0] idx);
        return idx[1:0] + idx[3:2] + idx[5:4] + idx[7:6] + {1'b0, idx[8]};
    endfunction

endpackage

// File: rtl/ntt_addr_gen_shifter.sv
// Fixed-depth shift register exposing every stage as a tap.
// A kill bit per stage clears the flag (MSB) of the word entering that stage.
module ntt_addr_gen_shifter #(
    parameter int data_width = 8,
    parameter int depth      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [depth-1:0]                       kill,
    input  logic [data_width-1:0]                  din,
    output logic [depth-1:0][data_width-1:0]       taps
);

    logic [depth-1:0][data_width-1:0] nxt;

    always_comb begin
        nxt    = '0;
        nxt[0] = din;
        for (int s = 1; s < depth; s++) begin
            nxt[s] = taps[s-1];
        end
        for (int s = 0; s < depth; s++) begin
            if (kill[s]) begin
                nxt[s][data_width-1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps <= nxt;
        end
    end

endmodule

// File: rtl/ntt_addr_gen.sv
// Turns NTT FSM loop indices into conflict-free bank addresses, lane routing
// and twiddle address, plus a latency-matched copy for butterfly write-back.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              sel,
    input  logic              sel_ntt,
    input  logic [6:0]        i,
    input  logic [6:0]        k,
    input  logic [6:0]        j,
    input  logic [2:0]        p,
    output logic              rd_valid,
    output logic [4*AW-1:0]   rd_addr,
    output logic [7:0]        rd_lane,
    output logic [8:0]        tw_addr,
    output logic              wr_valid,
    output logic [4*AW-1:0]   wr_addr,
    output logic [7:0]        wr_lane
);

    logic [NBANK-1:0][8:0]    idx;
    logic [8:0]               stride;
    logic [8:0]               group;
    logic [1:0]               bank;
    logic [1:0]               mm;
    logic [7:0]               tw_low;
    logic [4*AW-1:0]          addr_c;
    logic [7:0]               lane_c;
    logic [8:0]               tw_c;

    always_comb begin
        stride = 9'd1 << {p, 1'b0};
        group  = (9'(k) << {p, 1'b0}) << 2;
        idx    = '0;
        addr_c = '0;
        lane_c = '0;
        bank   = '0;
        mm     = '0;
        for (int m = 0; m < NBANK; m++) begin
            mm = 2'(m);
            // radix-2 lanes sit at i, i+256, i+128, i+384
            if (sel) begin
                idx[m] = group + 9'(m) * stride + 9'(j);
            end else begin
                idx[m] = {mm[0], mm[1], i};
            end
            bank = bank_of(idx[m]);
            addr_c[int'(bank)*AW +: AW] = idx[m][8:2];
            lane_c[int'(bank)*2 +: 2]   = mm;
        end
        tw_low = sel ? TW_BASE_R4[p[1:0]] + 8'(j) : TW_BASE_R2 + 8'(i);
        tw_c   = (sel_ntt ? TW_INTT_OFS : 9'd0) + {1'b0, tw_low};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_lane  <= '0;
            tw_addr  <= '0;
        end else begin
            rd_valid <= en_in;
            if (en_in) begin
                rd_addr <= addr_c;
                rd_lane <= lane_c;
                tw_addr <= tw_c;
            end
        end
    end

    logic [LAT_R4-1:0]          kill;
    logic [LAT_R4-1:0][DW-1:0]  taps;
    logic [DW-1:0]              tap;

    // In a radix-2 pass entries die after the short tap so a later
    // switch to the long tap cannot emit them a second time.
    always_comb begin
        kill = '0;
        if (LAT_R2 < LAT_R4) begin
            kill[LAT_R2 % LAT_R4] = ~sel;
        end
    end

    ntt_addr_gen_shifter #(
        .data_width (DW),
        .depth      (LAT_R4)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .kill (kill),
        .din  ({rd_valid, rd_addr, rd_lane}),
        .taps (taps)
    );

    assign tap = sel ? taps[LAT_R4-1] : taps[LAT_R2-1];
    assign {wr_valid, wr_addr, wr_lane} = tap;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: arithmetic reference model of index, bank and twiddle
// rules, with a cycle history used to predict the write-back path.
module tb_ntt_addr_gen;
    import ntt_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            en_in;
    logic            sel;
    logic            sel_ntt;
    logic [6:0]      i;
    logic [6:0]      k;
    logic [6:0]      j;
    logic [2:0]      p;
    logic            rd_valid;
    logic [4*AW-1:0] rd_addr;
    logic [7:0]      rd_lane;
    logic [8:0]      tw_addr;
    logic            wr_valid;
    logic [4*AW-1:0] wr_addr;
    logic [7:0]      wr_lane;

    ntt_addr_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en_in    (en_in),
        .sel      (sel),
        .sel_ntt  (sel_ntt),
        .i        (i),
        .k        (k),
        .j        (j),
        .p        (p),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .rd_lane  (rd_lane),
        .tw_addr  (tw_addr),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_lane  (wr_lane)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int epoch = 0;

    logic            m_v;
    logic [4*AW-1:0] m_addr;
    logic [7:0]      m_lane;
    logic [8:0]      m_tw;

    logic            h_v    [0:4095];
    logic [4*AW-1:0] h_addr [0:4095];
    logic [7:0]      h_lane [0:4095];

    int   seen [0:3][0:127];
    bit   cov_on = 0;
    bit   trk_on = 0;
    int   first_rd;
    int   first_wr;
    int   wr_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_idx(input int mm);
        int pp;
        int ofs [4];
        ofs = '{0, 256, 128, 384};
        pp = int'(p);
        if (sel) return (int'(k) * (4 ** (pp + 1)) + mm * (4 ** pp) + int'(j)) % 512;
        return (int'(i) + ofs[mm]) % 512;
    endfunction

    function automatic int ref_bank(input int x);
        return (x % 4 + (x / 4) % 4 + (x / 16) % 4 + (x / 64) % 4 + x / 256) % 4;
    endfunction

    task automatic model_reset();
        m_v = 1'b0;
        m_addr = '0;
        m_lane = '0;
        m_tw = '0;
    endtask

    task automatic model_edge();
        int x;
        int b;
        int low;
        if (en_in) begin
            m_v = 1'b1;
            for (int mm = 0; mm < 4; mm++) begin
                x = ref_idx(mm);
                b = ref_bank(x);
                m_addr[b*AW +: AW] = 7'(x / 4);
                m_lane[b*2 +: 2] = 2'(mm);
            end
            // radix-4 twiddle base for stage p is (4^p - 1) / 3
            low = sel ? ((4 ** int'(p)) - 1) / 3 + int'(j) : 85 + int'(i);
            m_tw = 9'((sel_ntt ? 256 : 0) + low);
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic check_all();
        int L;
        int src;
        logic            ev;
        logic [4*AW-1:0] ea;
        logic [7:0]      el;
        logic [3:0]      mask;
        L = sel ? LAT_R4 : LAT_R2;
        src = cyc - L;
        ev = 1'b0;
        ea = '0;
        el = '0;
        if (src >= epoch) begin
            ev = h_v[src];
            ea = h_addr[src];
            el = h_lane[src];
        end
        chk("rd_valid", 64'(rd_valid), 64'(m_v));
        chk("rd_addr", 64'(rd_addr), 64'(m_addr));
        chk("rd_lane", 64'(rd_lane), 64'(m_lane));
        chk("tw_addr", 64'(tw_addr), 64'(m_tw));
        chk("wr_valid", 64'(wr_valid), 64'(ev));
        chk("wr_addr", 64'(wr_addr), 64'(ea));
        chk("wr_lane", 64'(wr_lane), 64'(el));
        if (m_v) begin
            mask = '0;
            for (int b = 0; b < 4; b++) mask[rd_lane[b*2 +: 2]] = 1'b1;
            chk("lane_perm", 64'(mask), 64'hF);
            if (cov_on) begin
                for (int b = 0; b < 4; b++) seen[b][rd_addr[b*AW +: AW]]++;
            end
        end
        if (trk_on) begin
            if (rd_valid && first_rd < 0) first_rd = cyc;
            if (wr_valid) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
            end
        end
    endtask

    task automatic step(input logic e, input logic s, input logic sn,
                        input int ii, input int kk, input int jj, input int pp);
        en_in = e;
        sel = s;
        sel_ntt = sn;
        i = 7'(ii);
        k = 7'(kk);
        j = 7'(jj);
        p = 3'(pp);
        @(posedge clk);
        model_edge();
        if (cyc > 4095) $fatal(1, "FAIL cycle_budget observed=%0d expected<4096", cyc);
        h_v[cyc] = m_v;
        h_addr[cyc] = m_addr;
        h_lane[cyc] = m_lane;
        #1;
        check_all();
        cyc++;
    endtask

    task automatic drain();
        repeat (LAT_R4 + 2) step(1'b0, sel, sel_ntt, int'(i), int'(k), int'(j), int'(p));
    endtask

    task automatic cov_clear();
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 128; w++) seen[b][w] = 0;
    endtask

    task automatic cov_check(input string tag);
        int n;
        n = 0;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 128; w++)
                if (seen[b][w] != 1) n++;
        chk(tag, 64'(n), 64'd0);
    endtask

    task automatic burst(input logic s, input int lat, input string tag);
        int pp;
        first_rd = -1;
        first_wr = -1;
        wr_cnt = 0;
        trk_on = 1;
        for (int n = 0; n < 128; n++) begin
            pp = $urandom_range(0, 3);
            step(1'b1, s, 1'b1, $urandom_range(0, 127),
                 $urandom_range(0, (128 >> (2 * pp)) - 1),
                 $urandom_range(0, (1 << (2 * pp)) - 1), pp);
        end
        drain();
        trk_on = 0;
        chk({tag, "_delay"}, 64'(first_wr - first_rd), 64'(lat));
        chk({tag, "_count"}, 64'(wr_cnt), 64'd128);
    endtask

    initial begin
        rst = 1'b1;
        en_in = 1'b0;
        sel = 1'b1;
        sel_ntt = 1'b0;
        i = '0;
        k = '0;
        j = '0;
        p = '0;
        model_reset();
        #2;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_rd_lane", 64'(rd_lane), 64'd0);
        chk("rst_tw_addr", 64'(tw_addr), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_lane", 64'(wr_lane), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        epoch = cyc;

        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 3);
        chk("t1_addr", 64'(rd_addr), 64'({7'd48, 7'd32, 7'd16, 7'd0}));
        chk("t1_lane", 64'(rd_lane), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        chk("t1_tw", 64'(tw_addr), 64'd21);
        step(1'b1, 1'b1, 1'b0, 0, 1, 0, 0);
        chk("t2_addr", 64'(rd_addr), 64'({7'd1, 7'd1, 7'd1, 7'd1}));
        chk("t2_lane", 64'(rd_lane), 64'({2'd2, 2'd1, 2'd0, 2'd3}));
        chk("t2_tw", 64'(tw_addr), 64'd0);
        drain();
        step(1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
        chk("t3_addr", 64'(rd_addr), 64'({7'd32, 7'd64, 7'd0, 7'd96}));
        chk("t3_lane", 64'(rd_lane), 64'({2'd2, 2'd1, 2'd0, 2'd3}));
        chk("t3_tw", 64'(tw_addr), 64'd86);
        drain();

        for (int pp = 3; pp >= 0; pp--) begin
            cov_clear();
            cov_on = 1;
            for (int g = 0; g < (128 >> (2 * pp)); g++) begin
                for (int jj = 0; jj < (1 << (2 * pp)); jj++) begin
                    if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 1'b0, 0, g, jj, pp);
                    step(1'b1, 1'b1, 1'b0, 0, g, jj, pp);
                end
            end
            cov_on = 0;
            cov_check($sformatf("cov_r4_p%0d", pp));
        end
        drain();
        cov_clear();
        cov_on = 1;
        for (int ii = 0; ii < 128; ii++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, ii, 0, 0, 0);
            step(1'b1, 1'b0, 1'b0, ii, 0, 0, 0);
        end
        cov_on = 0;
        cov_check("cov_r2");
        drain();

        burst(1'b1, LAT_R4, "r4");
        burst(1'b0, LAT_R2, "r2");
        step(1'b1, 1'b0, 1'b1, 127, 0, 0, 0);
        chk("tw_intt_r2_max", 64'(tw_addr), 64'd468);
        drain();

        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0, 0, n, 0, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("mid_rst_rd_lane", 64'(rd_lane), 64'd0);
        chk("mid_rst_tw_addr", 64'(tw_addr), 64'd0);
        chk("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_wr_lane", 64'(wr_lane), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        epoch = cyc;
        first_rd = -1;
        first_wr = -1;
        wr_cnt = 0;
        trk_on = 1;
        repeat (LAT_R4 + 6) step(1'b0, 1'b1, 1'b0, 0, 0, 0, 2);
        trk_on = 0;
        chk("no_stale_wr", 64'(wr_cnt), 64'd0);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b1, 0, n, 3, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
